// File: rtl/rle_encoder_pkg.sv
// rle_encoder_pkg: shared widths, word flag and word builder for the capture RLE path
package rle_encoder_pkg;
  localparam int DW = 16;
  localparam int CW = 15;
  localparam int SW = 25;
  localparam int RLE_FLAG_BIT = 15;
  localparam logic [CW-1:0] RUN_MAX = 15'h7FFF;
  typedef enum logic {SAMPLE = 1'b0, COUNT = 1'b1} word_t;
  function automatic logic [DW-1:0] mk_word(word_t t, logic [CW-1:0] p);
    return {logic'(t), p};
  endfunction
endpackage

// File: rtl/rle_encoder_if.sv
// rle_encoder_if: raw capture sample in, encoded word stream out
interface rle_encoder_if;
  import rle_encoder_pkg::*;
  logic [DW-1:0] capture_data;
  logic [DW-1:0] rle_data;
  logic rle_valid;
  logic [SW-1:0] rle_sample_cnt;
  modport master (input capture_data, output rle_data, rle_valid, rle_sample_cnt);
  modport slave (output capture_data, input rle_data, rle_valid, rle_sample_cnt);
endinterface

// File: rtl/rle_out_queue.sv
// rle_out_queue: 2-entry FIFO taking up to two words per cycle, head bypasses when empty
module rle_out_queue
  import rle_encoder_pkg::*;
(
  input  logic core_clk,
  input  logic core_rst_n,
  input  logic [1:0] push_n,
  input  logic [DW-1:0] w0,
  input  logic [DW-1:0] w1,
  output logic [DW-1:0] head,
  output logic head_valid
);
  logic [DW-1:0] mem [2];
  logic [1:0] cnt;
  logic [2:0] avail;
  logic [DW-1:0] e1, e2;
  // held words come out ahead of this cycle's pushes; e1/e2 are what remains after the pop
  always_comb begin
    avail = {1'b0, cnt} + {1'b0, push_n};
    head = cnt != 2'd0 ? mem[0] : w0;
    head_valid = avail != 3'd0;
    e1 = cnt == 2'd2 ? mem[1] : cnt == 2'd1 ? w0 : w1;
    e2 = cnt == 2'd2 ? w0 : w1;
  end
  always_ff @(posedge core_clk or negedge core_rst_n)
    if (!core_rst_n) begin
      cnt <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      cnt <= head_valid ? 2'(avail - 3'd1) : 2'd0;
      mem[0] <= e1;
      mem[1] <= e2;
    end
  assert property (@(posedge core_clk) disable iff (!core_rst_n) avail <= 3'd3);
endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: run-length encodes capture_data[14:0] into sample/count words
module rle_encoder
  import rle_encoder_pkg::*;
(
  input  logic core_clk,
  input  logic core_rst_n,
  rle_encoder_if.master bus
);
  logic has_cur, same, sat, unused_ch15;
  logic [CW-1:0] cur, run, x;
  logic [1:0] push_n;
  logic [DW-1:0] w0, w1, head;
  logic head_valid;
  always_comb begin
    x = bus.capture_data[CW-1:0];
    unused_ch15 = bus.capture_data[RLE_FLAG_BIT];
    same = has_cur && x == cur;
    sat = same && run == RUN_MAX;
    push_n = !has_cur ? 2'd1 : same ? {1'b0, sat} : run != '0 ? 2'd2 : 2'd1;
    w0 = (sat || (has_cur && !same && run != '0)) ? mk_word(COUNT, run) : mk_word(SAMPLE, x);
    w1 = mk_word(SAMPLE, x);
  end
  rle_out_queue u_q (
    .core_clk(core_clk),
    .core_rst_n(core_rst_n),
    .push_n(push_n),
    .w0(w0),
    .w1(w1),
    .head(head),
    .head_valid(head_valid)
  );
  // a saturated run restarts at 1: this sample is the first repeat of the next chunk
  always_ff @(posedge core_clk or negedge core_rst_n)
    if (!core_rst_n) begin
      has_cur <= 1'b0;
      cur <= '0;
      run <= '0;
      bus.rle_data <= '0;
      bus.rle_valid <= 1'b0;
      bus.rle_sample_cnt <= '0;
    end else begin
      has_cur <= 1'b1;
      if (!same) cur <= x;
      run <= !same ? '0 : sat ? CW'(1) : run + 1'b1;
      bus.rle_valid <= head_valid;
      if (head_valid) bus.rle_data <= head;
      bus.rle_sample_cnt <= bus.rle_sample_cnt +
        (!head_valid ? SW'(0) : head[RLE_FLAG_BIT] ? SW'(head[CW-1:0]) : SW'(1));
    end
endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: directed RLE streams checked cycle by cycle against a word-backlog model
module tb_rle_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rle_encoder_if bus ();
  rle_encoder dut (.core_clk(clk), .core_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  logic [15:0] got [$];
  logic [15:0] pend [$];
  bit m_has;
  logic [14:0] m_cur;
  int m_rep;
  logic e_valid;
  logic [15:0] e_data;
  logic [24:0] e_cnt;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_has = 0; m_cur = '0; m_rep = 0; pend.delete();
    e_valid = 0; e_data = '0; e_cnt = '0;
  endtask

  // words produced by each input join a backlog drained one per cycle
  task automatic model_clk(input logic [15:0] d);
    logic [14:0] s;
    s = d[14:0];
    if (!m_has) begin
      pend.push_back({1'b0, s}); m_has = 1; m_cur = s; m_rep = 0;
    end else if (s == m_cur) begin
      m_rep++;
      if (m_rep == 32768) begin pend.push_back(16'hFFFF); m_rep = 1; end
    end else begin
      if (m_rep > 0) pend.push_back({1'b1, 15'(m_rep)});
      pend.push_back({1'b0, s}); m_cur = s; m_rep = 0;
    end
    e_valid = pend.size() > 0;
    if (e_valid) begin
      e_data = pend.pop_front();
      e_cnt += e_data[15] ? 25'(e_data[14:0]) : 25'd1;
    end
  endtask

  task automatic step(input logic [15:0] d);
    bus.capture_data = d;
    @(posedge clk);
    model_clk(d);
    @(negedge clk);
    check("rle_valid", 32'(bus.rle_valid), 32'(e_valid));
    check("rle_data", 32'(bus.rle_data), 32'(e_data));
    check("rle_sample_cnt", 32'(bus.rle_sample_cnt), 32'(e_cnt));
    check("backlog", 32'(pend.size() <= 1), 32'd1);
    if (bus.rle_valid) got.push_back(bus.rle_data);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    got.delete();
    check("rst_valid", 32'(bus.rle_valid), 32'd0);
    check("rst_data", 32'(bus.rle_data), 32'd0);
    check("rst_cnt", 32'(bus.rle_sample_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string n, input logic [15:0] exp [$]);
    check({n, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", n, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    bus.capture_data = '0;
    model_reset();
    @(negedge clk);
    reset_dut();
    for (int i = 0; i < 5; i++) step(16'h1234);
    step(16'h0001); step(16'h0001);
    check_log("const_then_change", '{16'h1234, 16'h8004, 16'h0001});
    check("const_cnt", 32'(bus.rle_sample_cnt), 32'd6);

    reset_dut();
    for (int i = 0; i < 20; i++) step(16'(i));
    check("incr_words", 32'(got.size()), 32'd20);
    check("incr_last", 32'(got[19]), 32'd19);

    reset_dut();
    step(16'h0AAA); step(16'h0AAA); step(16'h0555); step(16'h0555); step(16'h0AAA); step(16'h0AAA);
    check_log("pairs", '{16'h0AAA, 16'h8001, 16'h0555, 16'h8001, 16'h0AAA});

    reset_dut();
    for (int i = 0; i < 32770; i++) step(16'h7FFF);
    step(16'h0000); step(16'h0000);
    check_log("saturate", '{16'h7FFF, 16'hFFFF, 16'h8002, 16'h0000});
    check("saturate_cnt", 32'(bus.rle_sample_cnt), 32'd32771);

    reset_dut();
    step(16'h8003); step(16'h0003); step(16'h0004); step(16'h0004);
    check_log("bit15", '{16'h0003, 16'h8001, 16'h0004});

    reset_dut();
    step(16'h0AAA); step(16'h0AAA); step(16'h0555);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.rle_valid), 32'd0);
    check("midrst_cnt", 32'(bus.rle_sample_cnt), 32'd0);
    check("midrst_data", 32'(bus.rle_data), 32'd0);
    @(negedge clk);
    model_reset();
    got.delete();
    rst_n = 1'b1;
    step(16'h0555); step(16'h0555); step(16'h0555);
    check_log("after_rst", '{16'h0555});
    check("after_rst_cnt", 32'(bus.rle_sample_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
